// File: rtl/sync_bus_scheduler.sv
// sync_bus_scheduler: round-robin sharing of one bus synchronizer, with a fixed enable hold window followed by a forced low gap
module sync_bus_scheduler #(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2((HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic [IW-1:0]                grant_id,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, win;
  logic found;
  // first asserted request at or above the pointer, wrapping to 0
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      ack <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      grant_id <= '0;
      busy <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (found) begin
          unsync_bus <= req_data[win*BUS_WIDTH +: BUS_WIDTH];
          grant_id <= win;
          ack <= NUM_REQ'(1) << win;
          bus_enable <= 1'b1;
          busy <= 1'b1;
          state <= HOLD;
          cnt <= '0;
          ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
        HOLD: if (cnt == CW'(HOLD_CYCLES - 1)) begin
          bus_enable <= 1'b0;
          state <= GAP;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
          busy <= 1'b0;
          state <= IDLE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sync_bus_scheduler.sv
// tb_sync_bus_scheduler: directed vector table plus hand sequences for arbitration, timing and reset corners
module tb_sync_bus_scheduler;
  logic CLK = 1'b0, RST = 1'b0;
  logic [3:0] req = '0, ack;
  logic [31:0] data = '0;
  logic [7:0] bus;
  logic en, busy;
  logic [1:0] gid;
  logic [1:0] req2 = '0, ack2;
  logic [15:0] data2 = '0;
  logic [7:0] bus2;
  logic en2, busy2;
  logic [0:0] gid2;
  int n_chk = 0, n_fail = 0, cyc = 0, last = 0;

  sync_bus_scheduler u1 (.CLK(CLK), .RST(RST), .req(req), .req_data(data), .ack(ack),
    .unsync_bus(bus), .bus_enable(en), .grant_id(gid), .busy(busy));
  sync_bus_scheduler #(.NUM_REQ(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u2 (.CLK(CLK), .RST(RST),
    .req(req2), .req_data(data2), .ack(ack2), .unsync_bus(bus2), .bus_enable(en2),
    .grant_id(gid2), .busy(busy2));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] req; logic [31:0] data;
    logic [3:0] ack; logic [7:0] bus; logic en; logic [1:0] gid; logic busy;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic [3:0] r, input logic [31:0] d, input logic [3:0] a,
                     input logic [7:0] b, input logic e, input logic [1:0] g, input logic bz);
    vec_t v;
    v.req = r; v.data = d; v.ack = a; v.bus = b; v.en = e; v.gid = g; v.busy = bz;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    req = '0;
    req2 = '0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic wait_ack(input string name, output bit ok);
    int t = 0;
    while (ack == 0 && t < 20) begin
      tick();
      t++;
    end
    ok = (ack != 0);
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    bit ok;
    int g;
    #3;
    chk("rst_ack", ack, 0);
    chk("rst_bus", bus, 0);
    chk("rst_en", en, 0);
    chk("rst_gid", gid, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    RST = 1'b1;

    // single request: 4 high, 4 low, then idle
    add(4'b0001, 32'hAA, 4'b0001, 8'hAA, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(4'b0000, 32'hAA, 0, 8'hAA, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(4'b0000, 32'hAA, 0, 8'hAA, 0, 0, 1);
    add(4'b0000, 32'hAA, 0, 8'hAA, 0, 0, 0);
    add(4'b0000, 32'hAA, 0, 8'hAA, 0, 0, 0);
    // data change in HOLD ignored, req[2] in GAP deferred to IDLE
    add(4'b0001, 32'h55, 4'b0001, 8'h55, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(4'b0000, 32'h66, 0, 8'h55, 1, 0, 1);
    add(4'b0000, 32'h66, 0, 8'h55, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(4'b0100, 32'h00770066, 0, 8'h55, 0, 0, 1);
    add(4'b0100, 32'h00770066, 0, 8'h55, 0, 0, 0);
    add(4'b0100, 32'h00770066, 4'b0100, 8'h77, 1, 2, 1);
    add(4'b0000, 32'h00770066, 0, 8'h77, 1, 2, 1);
    for (int i = 0; i < tv.size(); i++) begin
      req = tv[i].req;
      data = tv[i].data;
      tick();
      chk($sformatf("v%0d_ack", i), ack, tv[i].ack);
      chk($sformatf("v%0d_bus", i), bus, tv[i].bus);
      chk($sformatf("v%0d_en", i), en, tv[i].en);
      chk($sformatf("v%0d_gid", i), gid, tv[i].gid);
      chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
    end

    // cancel: request withdrawn before any sampling edge
    for (int t = 0; t < 20 && busy; t++) tick();
    chk("cancel_idle", busy, 0);
    req = 4'b0100;
    #2;
    req = 4'b0000;
    tick();
    chk("cancel_ack", ack, 0);
    chk("cancel_en", en, 0);
    tick();
    chk("cancel_en2", en, 0);

    // simultaneous 1010: 1,3,1,3 with 9-cycle enable spacing
    do_reset();
    data = 32'h33001100;
    req = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      wait_ack($sformatf("pair%0d", n), ok);
      if (ok) begin
        g = (n % 2) ? 3 : 1;
        chk($sformatf("pair%0d_gid", n), gid, g);
        chk($sformatf("pair%0d_ack", n), ack, 1 << g);
        chk($sformatf("pair%0d_bus", n), bus, (n % 2) ? 8'h33 : 8'h11);
        chk($sformatf("pair%0d_en", n), en, 1);
        if (n > 0) chk($sformatf("pair%0d_space", n), cyc - last, 9);
        last = cyc;
      end
      tick();
    end

    // full fairness
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack($sformatf("fair%0d", n), ok);
      if (ok) begin
        chk($sformatf("fair%0d_gid", n), gid, n % 4);
        chk($sformatf("fair%0d_ack", n), ack, 1 << (n % 4));
      end
      tick();
    end

    // reset in second HOLD cycle
    do_reset();
    data = 32'h00CCDD00;
    req = 4'b0010;
    tick();
    chk("mid_grant", ack, 4'b0010);
    req = 4'b0000;
    tick();
    chk("mid_hold_en", en, 1);
    RST = 1'b0;
    #1;
    chk("mid_rst_en", en, 0);
    chk("mid_rst_bus", bus, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_gid", gid, 0);
    tick();
    RST = 1'b1;
    tick();
    chk("post_rst_ack", ack, 0);
    chk("post_rst_en", en, 0);
    req = 4'b0110;
    tick();
    chk("post_rst_grant", ack, 4'b0010);
    chk("post_rst_gid", gid, 1);
    chk("post_rst_bus", bus, 8'hDD);

    // HOLD=1, GAP=1, two requesters
    do_reset();
    data2 = 16'hB1A0;
    req2 = 2'b11;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("p2_en%0d", k), en2, (k % 3) == 0);
      if ((k % 3) == 0) begin
        g = (k / 3) % 2;
        chk($sformatf("p2_gid%0d", k), gid2, g);
        chk($sformatf("p2_ack%0d", k), ack2, 1 << g);
        chk($sformatf("p2_bus%0d", k), bus2, g ? 8'hB1 : 8'hA0);
      end else chk($sformatf("p2_ack%0d", k), ack2, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_bus_scheduler.md
Name: sync_bus_scheduler

Overview:
- Source-domain scheduler that shares one DATA_SYNC bus synchronizer between NUM_REQ requesters.
- Arbitrates round-robin and registers the winner's word onto unsync_bus.
- Asserts bus_enable for a fixed hold window, then forces a low gap so the destination sees a fresh enable edge per transfer.
- Sits directly in front of DATA_SYNC; its unsync_bus/bus_enable outputs connect straight to DATA_SYNC inputs.

Parameters:
- BUS_WIDTH, 8, width of each data word and of unsync_bus.
- NUM_REQ, 4, number of requesters (>=2).
- HOLD_CYCLES, 4, cycles bus_enable stays high per transfer (>=1; default = NUM_STAGES+2 for NUM_STAGES=2).
- GAP_CYCLES, 4, cycles bus_enable is forced low after each hold (>=1).

Ports:
- CLK  input  1  source-domain clock; all logic on rising edge.
- RST  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester transfer request, level; sampled only in IDLE.
- req_data  input  NUM_REQ*BUS_WIDTH  word i at bits [i*BUS_WIDTH +: BUS_WIDTH]; sampled with req.
- ack  output  NUM_REQ  one-cycle pulse: requester's word captured.
- unsync_bus  output  BUS_WIDTH  registered word presented to DATA_SYNC.
- bus_enable  output  1  registered enable to DATA_SYNC.
- grant_id  output  clog2(NUM_REQ)  index of current/last granted requester.
- busy  output  1  high in HOLD and GAP.

Behaviour:
- Reset (RST=0, immediate):
  - state=IDLE.
  - unsync_bus, bus_enable, ack, grant_id, busy, counter = 0.
  - Priority pointer = 0.
- Reset mid-HOLD/GAP aborts the transfer; no ack is re-issued after reset release.
- States: IDLE, HOLD, GAP.
- IDLE, req==0: stay; all outputs hold, ack=0.
- IDLE, req!=0: pick the first asserted index searching upward from the pointer, wrapping at NUM_REQ-1 -> 0. At the next edge:
  - unsync_bus <= that word; grant_id <= index; ack[index] <= 1 for exactly 1 cycle.
  - bus_enable <= 1; busy <= 1; state <= HOLD; counter <= 0.
  - pointer <= (index+1) mod NUM_REQ.
- HOLD: bus_enable=1 for exactly HOLD_CYCLES cycles. On the last cycle: bus_enable <= 0, state <= GAP, counter <= 0.
- GAP: bus_enable=0 for exactly GAP_CYCLES cycles. unsync_bus is held stable through HOLD and GAP. After the last cycle: state <= IDLE, busy <= 0.
- unsync_bus stays at its last value in IDLE; it changes only on a grant.
- Minimum spacing between successive bus_enable rising edges = HOLD_CYCLES+GAP_CYCLES+1 cycles. The IDLE arbitration cycle is always present.
- Requester handshake:
  - After ack[i], the requester may change req_data or drop req.
  - req held high after ack is treated as a new request at the next IDLE.
  - Dropping req before grant cancels it silently.
- req/req_data changes during HOLD/GAP are ignored.
- Simultaneous requests: exactly one grant per IDLE decision. Round-robin guarantees any continuously asserted requester is granted within NUM_REQ transfers.
- ack is one-hot or zero; never more than one bit set.
- Counter width clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); no other arithmetic.

Test Plan:
1. Single request: after reset, req=4'b0001, word0=8'hAA. Expected:
   - ack=0001 pulses one cycle after req is sampled.
   - unsync_bus=AA; bus_enable high exactly 4 cycles, then low 4 cycles; busy high for 8 cycles.
   - With DATA_SYNC (NUM_STAGES=2) attached, sync_bus=AA and one enable_pulse.
2. Simultaneous requests: req=4'b1010 held, words 8'h11 (idx1) and 8'h33 (idx3). Expected:
   - Grant order 1,3,1,3; unsync_bus sequence 11,33,11,33.
   - bus_enable rising edges exactly 9 cycles apart.
3. Full fairness: req=4'b1111 held from reset. Expected:
   - grant_id sequence 0,1,2,3,0.
   - Each ack bit pulses once per 4 transfers.
4. Cancel and ignore:
   - req=4'b0100 dropped before IDLE sampling -> no ack, bus_enable stays 0.
   - req[2] asserted during GAP -> granted only after return to IDLE.
   - req_data changed during HOLD -> unsync_bus unchanged.
5. Reset mid-HOLD: assert RST=0 on cycle 2 of HOLD. Expected:
   - bus_enable, unsync_bus, busy, ack drop to 0 immediately.
   - After release, pointer=0 and the next grant goes to the lowest asserted index.
6. Parameter corner: HOLD_CYCLES=1, GAP_CYCLES=1, NUM_REQ=2, req=2'b11 held. Expected:
   - bus_enable pattern 1,0,0 repeating (period 3).
   - Grants alternate 0,1.
